mod_updown_counter: RTL

- Parametrised synchronous modulo-N up/down counter. Successor to the fixed 2-bit counter in the counter library.
- Adds the following over the fixed counter:
  - arbitrary width and modulus
  - direction control
  - parallel load
  - enable
  - wrap or saturate mode
  - terminal-count, wrap-event and sticky overflow flags
  - a Gray-coded copy of the count
- Used as a timebase/event counter feeding other blocks. All outputs are registered except tc.

---
 rtl/cnt_pkg.sv | 21 ++
 rtl/cnt_bin2gray.sv | 22 ++
 rtl/mod_updown_counter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the modulo-N up/down counter family:
//   - DIR_UP / DIR_DOWN : encoding of the 'up' direction input
//   - GRAY_MAX_W        : widest vector the generic Gray helper accepts
//   - bin2gray()        : binary to reflected-Gray conversion; callers
//                         zero-extend into and truncate out of GRAY_MAX_W
// ---------------------------------------------------------------------------
package cnt_pkg;

    localparam int unsigned GRAY_MAX_W = 64;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Reflected binary Gray code: each bit is the XOR with its upper neighbour.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/cnt_bin2gray.sv
// ---------------------------------------------------------------------------
// cnt_bin2gray
// Purely combinational binary-to-Gray encoder of parametrised width.
// Ports:
//   bin    [WIDTH-1:0] in  : binary value
//   gray_c [WIDTH-1:0] out : Gray code of bin (combinational)
// ---------------------------------------------------------------------------
module cnt_bin2gray
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    // Upper bits of the widened input are zero, so truncation is lossless.
    always_comb begin
        gray_c = WIDTH'(bin2gray(GRAY_MAX_W'(bin)));
    end

endmodule

// File: rtl/mod_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_updown_counter
// Parametrised modulo-N up/down counter with parallel load, enable,
// wrap or saturate behaviour at the range ends, and event flags.
// Parameters:
//   the register is WIDTH bits wide (at least 2); the modulus gives a count
//   range of 0 up to modulus-1 (2..2**WIDTH); SATURATE selects hold (1) or
//   wrap (0) at the range ends
// Ports:
//   clk                    in  : rising-edge clock
//   rst                    in  : asynchronous active-high reset
//   en                     in  : count enable
//   up                     in  : direction, 1 = increment, 0 = decrement
//   load                   in  : parallel load strobe (beats en)
//   load_val [WIDTH-1:0]   in  : value to load, clamped to the top of range
//   ovf_clr                in  : clears the sticky overflow flag
//   cnt      [WIDTH-1:0]   out : registered binary count
//   cnt_gray [WIDTH-1:0]   out : registered Gray code of cnt
//   tc                     out : terminal count, combinational
//   wrap                   out : registered one-cycle end-of-range pulse
//   ovf                    out : registered sticky end-of-range flag
// ---------------------------------------------------------------------------
module mod_updown_counter
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MOD      = 10,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam int unsigned   EXT_W   = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    // Reject illegal parameter combinations at elaboration.
    if ((WIDTH < 2) || (MOD < 2) || (64'(MOD) > (64'd1 << WIDTH))) begin : g_param_check
        $error("mod_updown_counter: illegal WIDTH/MOD combination");
    end

    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q,  ovf_d;

    logic             at_max_c;
    logic             at_min_c;
    logic             eor_c;
    logic [EXT_W-1:0] step_c;

    // End-of-range detection and the +/-1 step, computed one bit wider.
    always_comb begin
        at_max_c = (cnt_q == MAX_VAL);
        at_min_c = (cnt_q == '0);
        eor_c    = en & ~load & (((up == DIR_UP)   & at_max_c) |
                                 ((up == DIR_DOWN) & at_min_c));
        if (up == DIR_UP) begin
            step_c = {1'b0, cnt_q} + EXT_W'(1);
        end else begin
            step_c = {1'b0, cnt_q} - EXT_W'(1);
        end
    end

    // Next-state: load beats count; end-of-range handled before plain stepping,
    // so step_c never leaves 0..MOD-1 when it is used.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;

        if (load) begin
            cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (eor_c) begin
            wrap_d = 1'b1;
            if (!SATURATE) begin
                cnt_d = (up == DIR_UP) ? '0 : MAX_VAL;
            end
        end else if (en) begin
            cnt_d = WIDTH'(step_c);
        end

        // A simultaneous event beats the clear.
        if (eor_c) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Gray copy is encoded from the next count so it lands with cnt.
    cnt_bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin    (cnt_d),
        .gray_c (gray_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_gray = gray_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;
    // Terminal count is forced low while reset is asserted.
    assign tc       = eor_c & ~rst;

endmodule
